// File: rtl/mmc3_mapper.sv
// mmc3_mapper: MMC3-class PRG/CHR banking, mirroring and A12 scanline IRQ.
// Ports: m2 (falls = update), reset_pin (async low), CPU bus in, PPU A13..A10 in; bank selects, CIRAM A10, irq out.
module mmc3_mapper #(
  parameter int PRG_BANK_BITS = 8,
  parameter int CHR_BANK_BITS = 10,
  parameter int A12_FILTER    = 3
) (
  input  logic                     m2,
  input  logic                     reset_pin,
  input  logic [7:0]               cpu_data,
  input  logic                     cpu_rw,
  input  logic                     romsel,
  input  logic [14:12]             cpu_addr,
  input  logic                     cpu_a0,
  input  logic [13:10]             ppu_addr,
  output logic [PRG_BANK_BITS:0]   cpu_bs,
  output logic                     cpu_enable,
  output logic                     cpu_read,
  output logic [CHR_BANK_BITS-1:0] ppu_bs,
  output logic                     ciram_a10,
  output logic                     irq
);

  localparam logic [3:0] FILT = 4'(A12_FILTER);

  logic [7:0][7:0] bank_q, bank_d;
  logic [2:0]      sel_q, sel_d;
  logic            prg_mode_q, prg_mode_d;
  logic            chr_inv_q, chr_inv_d;
  logic            mirror_q, mirror_d;
  logic [7:0]      latch_q, latch_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            reload_q, reload_d;
  logic            irq_en_q, irq_en_d;
  logic            pend_q, pend_d;
  logic [3:0]      low_q, low_d;
  logic            a12_prev_q, a12_prev_d;

  logic       wr;
  logic [2:0] key;
  logic       w_sel, w_bank, w_mir, w_lat;
  logic       w_rld, w_dis, w_en;
  logic       a12, count;

  assign wr  = ~romsel & ~cpu_rw;
  assign key = {cpu_addr[14:13], cpu_a0};
  assign a12 = ppu_addr[12];

  // Counted rise: fresh 0->1 transition after a full run of low samples.
  assign count = a12 & ~a12_prev_q & (low_q == FILT);

  always_comb begin
    w_sel  = 1'b0;
    w_bank = 1'b0;
    w_mir  = 1'b0;
    w_lat  = 1'b0;
    w_rld  = 1'b0;
    w_dis  = 1'b0;
    w_en   = 1'b0;
    if (wr) begin
      unique case (key)
        3'b000: w_sel  = 1'b1;
        3'b001: w_bank = 1'b1;
        3'b010: w_mir  = 1'b1;
        3'b011: ;
        3'b100: w_lat  = 1'b1;
        3'b101: w_rld  = 1'b1;
        3'b110: w_dis  = 1'b1;
        3'b111: w_en   = 1'b1;
      endcase
    end
  end

  always_comb begin
    bank_d     = bank_q;
    sel_d      = sel_q;
    prg_mode_d = prg_mode_q;
    chr_inv_d  = chr_inv_q;
    mirror_d   = mirror_q;
    latch_d    = latch_q;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    irq_en_d   = irq_en_q;
    pend_d     = pend_q;

    if (w_sel) begin
      sel_d      = cpu_data[2:0];
      prg_mode_d = cpu_data[6];
      chr_inv_d  = cpu_data[7];
    end
    if (w_bank) bank_d[sel_q] = cpu_data;
    if (w_mir)  mirror_d = cpu_data[0];
    if (w_lat)  latch_d = cpu_data;
    if (w_dis) begin
      irq_en_d = 1'b0;
      pend_d   = 1'b0;
    end
    if (w_en)   irq_en_d = 1'b1;
    if (w_rld) begin
      cnt_d    = 8'd0;
      reload_d = 1'b1;
    end

    // Same-edge writes are folded in first, so the
    // edge sees the freshly written latch/reload/enable.
    if (count) begin
      if (cnt_d == 8'd0 || reload_d) begin
        cnt_d    = latch_d;
        reload_d = 1'b0;
      end else begin
        cnt_d = cnt_d - 8'd1;
      end
      if (cnt_d == 8'd0 && irq_en_d) pend_d = 1'b1;
    end
  end

  always_comb begin
    a12_prev_d = a12;
    if (a12)               low_d = 4'd0;
    else if (low_q < FILT) low_d = low_q + 4'd1;
    else                   low_d = low_q;
  end

  always_ff @(negedge m2 or negedge reset_pin) begin
    if (!reset_pin) begin
      bank_q     <= {8'h01, 56'h0};
      sel_q      <= 3'd0;
      prg_mode_q <= 1'b0;
      chr_inv_q  <= 1'b0;
      mirror_q   <= 1'b0;
      latch_q    <= 8'd0;
      cnt_q      <= 8'd0;
      reload_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      pend_q     <= 1'b0;
      low_q      <= 4'd0;
      a12_prev_q <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      sel_q      <= sel_d;
      prg_mode_q <= prg_mode_d;
      chr_inv_q  <= chr_inv_d;
      mirror_q   <= mirror_d;
      latch_q    <= latch_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      irq_en_q   <= irq_en_d;
      pend_q     <= pend_d;
      low_q      <= low_d;
      a12_prev_q <= a12_prev_d;
    end
  end

  // PRG banking
  logic [PRG_BANK_BITS-1:0] r6_p, r7_p;
  logic [PRG_BANK_BITS-1:0] last_b, slast_b, bank8k;

  if (PRG_BANK_BITS > 8) begin : g_prg_ext
    assign r6_p = {{(PRG_BANK_BITS-8){1'b0}}, bank_q[6]};
    assign r7_p = {{(PRG_BANK_BITS-8){1'b0}}, bank_q[7]};
  end else if (PRG_BANK_BITS == 8) begin : g_prg_eq
    assign r6_p = bank_q[6];
    assign r7_p = bank_q[7];
  end else begin : g_prg_trunc
    logic unused_prg;
    assign r6_p = bank_q[6][PRG_BANK_BITS-1:0];
    assign r7_p = bank_q[7][PRG_BANK_BITS-1:0];
    assign unused_prg = ^{bank_q[6][7:PRG_BANK_BITS],
                          bank_q[7][7:PRG_BANK_BITS]};
  end

  assign last_b  = '1;
  assign slast_b = last_b - PRG_BANK_BITS'(1);

  always_comb begin
    bank8k = last_b;
    unique case (cpu_addr[14:13])
      2'b00: bank8k = prg_mode_q ? slast_b : r6_p;
      2'b01: bank8k = r7_p;
      2'b10: bank8k = prg_mode_q ? r6_p : slast_b;
      2'b11: bank8k = last_b;
    endcase
  end

  assign cpu_bs     = {bank8k, cpu_addr[12]};
  assign cpu_enable = ~romsel;
  assign cpu_read   = ~romsel & cpu_rw;

  // CHR banking; chr_inv swaps the 2 KiB and 1 KiB halves
  logic [2:0] chr_k;
  logic [7:0] chr8;

  assign chr_k = ppu_addr[12:10] ^ {chr_inv_q, 2'b00};

  always_comb begin
    chr8 = bank_q[2];
    unique case (chr_k)
      3'd0, 3'd1: chr8 = {bank_q[0][7:1], ppu_addr[10]};
      3'd2, 3'd3: chr8 = {bank_q[1][7:1], ppu_addr[10]};
      3'd4:       chr8 = bank_q[2];
      3'd5:       chr8 = bank_q[3];
      3'd6:       chr8 = bank_q[4];
      3'd7:       chr8 = bank_q[5];
    endcase
  end

  if (CHR_BANK_BITS > 8) begin : g_chr_ext
    assign ppu_bs = {{(CHR_BANK_BITS-8){1'b0}}, chr8};
  end else if (CHR_BANK_BITS == 8) begin : g_chr_eq
    assign ppu_bs = chr8;
  end else begin : g_chr_trunc
    logic unused_chr;
    assign ppu_bs = chr8[CHR_BANK_BITS-1:0];
    assign unused_chr = ^chr8[7:CHR_BANK_BITS];
  end

  assign ciram_a10 = mirror_q ? ppu_addr[11] : ppu_addr[10];
  assign irq       = ~pend_q;

  logic unused_ppu;
  assign unused_ppu = ppu_addr[13];

endmodule

// File: tb/tb_mmc3_mapper.sv
// tb_mmc3_mapper: directed stimulus, per-cycle model compare, literal pins.
// Drives on m2 high phase; design updates on m2 fall.
module tb_mmc3_mapper;

  localparam int PB = 8;
  localparam int CB = 10;
  localparam int F  = 3;

  logic          m2, reset_pin;
  logic [7:0]    cpu_data;
  logic          cpu_rw, romsel, cpu_a0;
  logic [14:12]  cpu_addr;
  logic [13:10]  ppu_addr;
  logic [PB:0]   cpu_bs;
  logic          cpu_enable, cpu_read;
  logic [CB-1:0] ppu_bs;
  logic          ciram_a10, irq;

  int tests = 0;
  int fails = 0;

  mmc3_mapper #(
    .PRG_BANK_BITS(PB),
    .CHR_BANK_BITS(CB),
    .A12_FILTER(F)
  ) dut (
    .m2(m2), .reset_pin(reset_pin),
    .cpu_data(cpu_data), .cpu_rw(cpu_rw),
    .romsel(romsel), .cpu_addr(cpu_addr),
    .cpu_a0(cpu_a0), .ppu_addr(ppu_addr),
    .cpu_bs(cpu_bs), .cpu_enable(cpu_enable),
    .cpu_read(cpu_read), .ppu_bs(ppu_bs),
    .ciram_a10(ciram_a10), .irq(irq)
  );

  initial m2 = 1'b1;
  always #5 m2 = ~m2;

  // ---- model state ----
  int mr[8];
  int msel, mlatch, mctr, mlows;
  bit mmode, minv, mmir, mreload, men, mpend, mprev;

  function automatic void mreset();
    for (int i = 0; i < 8; i++) mr[i] = 0;
    mr[7] = 1;
    msel = 0; mlatch = 0; mctr = 0; mlows = 0;
    mmode = 0; minv = 0; mmir = 0;
    mreload = 0; men = 0; mpend = 0; mprev = 0;
  endfunction

  // Writes apply first; a counted A12 rise then acts on the result.
  function automatic void mstep();
    int key;
    bit a;
    if (!romsel && !cpu_rw) begin
      key = int'(cpu_addr[14:13]) * 2 + int'(cpu_a0);
      case (key)
        0: begin
          msel  = int'(cpu_data) % 8;
          mmode = cpu_data[6];
          minv  = cpu_data[7];
        end
        1: mr[msel] = int'(cpu_data);
        2: mmir = cpu_data[0];
        4: mlatch = int'(cpu_data);
        5: begin mctr = 0; mreload = 1; end
        6: begin men = 0; mpend = 0; end
        7: men = 1;
        default: ;
      endcase
    end
    a = ppu_addr[12];
    if (a && !mprev && mlows == F) begin
      if (mctr == 0 || mreload) begin
        mctr = mlatch;
        mreload = 0;
      end else begin
        mctr = mctr - 1;
      end
      if (mctr == 0 && men) mpend = 1;
    end
    if (a) mlows = 0;
    else if (mlows < F) mlows = mlows + 1;
    mprev = a;
  endfunction

  function automatic int exp_cpu_bs();
    int slot, last, b;
    slot = int'(cpu_addr[14:13]);
    last = (1 << PB) - 1;
    if (slot == 3)      b = last;
    else if (slot == 1) b = mr[7] & last;
    else if ((slot == 0) == mmode) b = last - 1;
    else                b = mr[6] & last;
    return b * 2 + int'(cpu_addr[12]);
  endfunction

  function automatic int exp_ppu_bs();
    int k, a10, v;
    k   = int'(ppu_addr[12:10]) ^ (minv ? 4 : 0);
    a10 = int'(ppu_addr[10]);
    if (k < 2)      v = (mr[0] & 'hFE) | a10;
    else if (k < 4) v = (mr[1] & 'hFE) | a10;
    else            v = mr[k - 2];
    return v & ((1 << CB) - 1);
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               name, got, exp);
    end
  endtask

  task automatic compare();
    check("cpu_bs", 32'(cpu_bs), 32'(exp_cpu_bs()));
    check("ppu_bs", 32'(ppu_bs), 32'(exp_ppu_bs()));
    check("ciram_a10", 32'(ciram_a10),
          32'(mmir ? ppu_addr[11] : ppu_addr[10]));
    check("cpu_enable", 32'(cpu_enable), 32'(!romsel));
    check("cpu_read", 32'(cpu_read),
          32'(!romsel && cpu_rw));
    check("irq", 32'(irq), 32'(!mpend));
  endtask

  always @(negedge reset_pin) mreset();

  always @(negedge m2) begin
    if (reset_pin) mstep();
    else mreset();
    #2;
    compare();
  end

  // ---- stimulus ----
  task automatic step(input logic rs, input logic rw,
                      input logic [2:0] a, input logic a0,
                      input logic [7:0] d,
                      input logic [3:0] p);
    @(posedge m2);
    #1;
    romsel = rs; cpu_rw = rw; cpu_addr = a;
    cpu_a0 = a0; cpu_data = d; ppu_addr = p;
  endtask

  task automatic wr(input logic [15:0] ad,
                    input logic [7:0] d,
                    input logic [3:0] p);
    step(1'b0, 1'b0, ad[14:12], ad[0], d, p);
  endtask

  task automatic look(input logic [2:0] a,
                      input logic [3:0] p);
    step(1'b1, 1'b1, a, 1'b0, 8'h00, p);
    #1;
  endtask

  task automatic idle(input logic [3:0] p);
    step(1'b1, 1'b1, 3'b000, 1'b0, 8'h00, p);
  endtask

  task automatic pulse(input int nlow);
    for (int i = 0; i < nlow; i++) idle(4'h0);
    idle(4'h4);
  endtask

  task automatic after_edge();
    @(negedge m2);
    #3;
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: run did not end, expected end");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    reset_pin = 1'b0;
    romsel = 1'b1; cpu_rw = 1'b1;
    cpu_addr = 3'b000; cpu_a0 = 1'b0;
    cpu_data = 8'h00; ppu_addr = 4'h0;
    mreset();
    #12;
    reset_pin = 1'b1;

    look(3'b000, 4'h0);
    check("rst_8000", 32'(cpu_bs), 32'h000);
    look(3'b110, 4'h0);
    check("rst_E000", 32'(cpu_bs), 32'h1FE);
    look(3'b100, 4'h0);
    check("rst_C000", 32'(cpu_bs), 32'h1FC);
    check("rst_irq", 32'(irq), 32'h1);
    look(3'b000, 4'h1);
    check("rst_a10_1", 32'(ciram_a10), 32'h1);
    look(3'b000, 4'h2);
    check("rst_a10_0", 32'(ciram_a10), 32'h0);

    wr(16'h8000, 8'h46, 4'h0);
    wr(16'h8001, 8'h05, 4'h0);
    look(3'b000, 4'h0);
    check("m1_8000", 32'(cpu_bs), 32'h1FC);
    look(3'b100, 4'h0);
    check("m1_C000", 32'(cpu_bs), 32'h00A);
    look(3'b101, 4'h0);
    check("m1_D000", 32'(cpu_bs), 32'h00B);

    wr(16'hA000, 8'h01, 4'h0);
    look(3'b000, 4'h2);
    check("horiz_a10", 32'(ciram_a10), 32'h1);

    wr(16'h8000, 8'h02, 4'h0);
    wr(16'h8001, 8'h37, 4'h0);
    wr(16'h8000, 8'h80, 4'h0);
    wr(16'h8001, 8'h13, 4'h0);
    look(3'b000, 4'h5);
    check("inv_1400", 32'(ppu_bs), 32'h013);
    look(3'b000, 4'h0);
    check("inv_0000", 32'(ppu_bs), 32'h037);

    wr(16'hC000, 8'h02, 4'h0);
    wr(16'hC001, 8'h00, 4'h0);
    wr(16'hE001, 8'h00, 4'h0);
    pulse(F); after_edge();
    check("irq_rise1", 32'(irq), 32'h1);
    pulse(F); after_edge();
    check("irq_rise2", 32'(irq), 32'h1);
    pulse(F); after_edge();
    check("irq_rise3", 32'(irq), 32'h0);
    wr(16'hE000, 8'h00, 4'h0); after_edge();
    check("irq_ack", 32'(irq), 32'h1);

    wr(16'hE001, 8'h00, 4'h0);
    pulse(F);
    pulse(1); after_edge();
    check("glitch", 32'(irq), 32'h1);
    pulse(F); after_edge();
    check("post_glitch1", 32'(irq), 32'h1);
    pulse(F); after_edge();
    check("post_glitch2", 32'(irq), 32'h0);

    wr(16'hE000, 8'h00, 4'h0);
    wr(16'hC000, 8'h00, 4'h0);
    wr(16'hE001, 8'h00, 4'h0);
    wr(16'hC001, 8'h00, 4'h4); after_edge();
    check("c001_edge", 32'(irq), 32'h0);
    wr(16'hE000, 8'h00, 4'h0);
    wr(16'hE001, 8'h00, 4'h0);
    idle(4'h0); idle(4'h0);
    wr(16'hE000, 8'h00, 4'h4); after_edge();
    check("e000_edge", 32'(irq), 32'h1);
    idle(4'h0); idle(4'h0); idle(4'h0);
    wr(16'hE001, 8'h00, 4'h4); after_edge();
    check("e001_edge", 32'(irq), 32'h0);

    wr(16'hE000, 8'h00, 4'h0);
    wr(16'hE001, 8'h00, 4'h0);
    wr(16'hC001, 8'h00, 4'h0);
    idle(4'h0);
    wr(16'hC000, 8'h05, 4'h4); after_edge();
    check("c000_edge", 32'(irq), 32'h1);
    for (int i = 0; i < 5; i++) begin
      pulse(F); after_edge();
      check("count5", 32'(irq), (i == 4) ? 32'h0 : 32'h1);
    end

    @(posedge m2);
    #2;
    reset_pin = 1'b0;
    #1;
    check("mid_rst_irq", 32'(irq), 32'h1);
    check("mid_rst_bs", 32'(cpu_bs), 32'h000);
    check("mid_rst_chr", 32'(ppu_bs), 32'h000);
    @(posedge m2);
    #1;
    reset_pin = 1'b1;

    wr(16'hC000, 8'h00, 4'h4);
    wr(16'hC001, 8'h00, 4'h4);
    wr(16'hE001, 8'h00, 4'h4);
    pulse(F - 1); after_edge();
    check("rst_filter", 32'(irq), 32'h1);
    pulse(F); after_edge();
    check("rst_first", 32'(irq), 32'h0);

    idle(4'h0);
    @(posedge m2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmc3_mapper.md
# mmc3_mapper

Parametrised successor to the cartridge's UNROM/MMC1 mapper logic: an MMC3-class banked mapper with eight bank registers, two PRG layout modes, CHR A12 inversion, software-selected mirroring and a scanline IRQ counter clocked by filtered PPU A12 rises. It sits between the console edge connector and the PRG flash / CHR RAM bank-select lines. Selected by the init-mode loader once the boot sequence completes. PRG and CHR bank widths are parameters, so the same block serves larger flash parts.

## Interface
Parameters:
- PRG_BANK_BITS, 8: width of the 8 KiB PRG bank number.
- CHR_BANK_BITS, 10: width of the 1 KiB CHR bank number.
- A12_FILTER, 3: number of consecutive m2 samples with A12 low required before an A12 rise is counted (1..15).

Ports:
- m2  in  1  clock; all state updates on the falling edge of m2.
- reset_pin  in  1  asynchronous, active-low reset.
- cpu_data  in  8  CPU data bus.
- cpu_rw  in  1  CPU read(1)/write(0).
- romsel  in  1  active-low $8000-$FFFF select.
- cpu_addr  in  [14:12]  CPU address bits.
- cpu_a0  in  1  CPU address bit 0.
- ppu_addr  in  [13:10]  PPU address bits.
- cpu_bs  out  PRG_BANK_BITS+1  flash bank select in 4 KiB units: {bank8k, cpu_addr[12]}.
- cpu_enable  out  1  PRG chip enable, equal to ~romsel.
- cpu_read  out  1  PRG read strobe, equal to ~romsel & cpu_rw.
- ppu_bs  out  CHR_BANK_BITS  CHR bank select in 1 KiB units.
- ciram_a10  out  1  nametable A10.
- irq  out  1  active-low IRQ to the CPU.

## Operation
- Register write: on the m2 falling edge with romsel=0 and cpu_rw=0, decode {cpu_addr[14:13], cpu_a0}:
  - 00,0: select. data[2:0] selects target R0-R7; data[6] sets prg_mode; data[7] sets chr_inv.
  - 00,1: R[target] <= data.
  - 01,0: mirror <= data[0].
  - 01,1: ignored.
  - 10,0: latch <= data.
  - 10,1: counter <= 0; reload <= 1.
  - 11,0: irq_en <= 0; pending <= 0.
  - 11,1: irq_en <= 1.
- PRG mapping: slot = cpu_addr[14:13]; L = all ones (last bank); S = L-1 (second-to-last bank).
  - prg_mode 0: slots 0-3 map to R6, R7, S, L.
  - prg_mode 1: slots 0-3 map to S, R7, R6, L.
  - R6 and R7 are zero-extended or truncated to PRG_BANK_BITS.
- CHR mapping: k = ppu_addr[12:10] ^ {chr_inv,2'b00}.
  - k=0,1: ppu_bs = {R0[7:1], ppu_addr[10]}.
  - k=2,3: ppu_bs = {R1[7:1], ppu_addr[10]}.
  - k=4..7: ppu_bs = R2..R5.
  - Values are zero-extended or truncated to CHR_BANK_BITS.
- Mirroring: ciram_a10 = mirror ? ppu_addr[11] : ppu_addr[10]. 0 is vertical, 1 is horizontal.
- A12 filter: low_cnt (4 bits) increments, saturating at A12_FILTER, on each falling edge with ppu_addr[12]=0. It clears on each falling edge with ppu_addr[12]=1.
- Counted edge: an edge counts when the sample shows ppu_addr[12]=1, the previous sample was 0, and low_cnt==A12_FILTER.
- Scanline counter: on a counted edge:
  - if counter==0 or reload==1: counter <= latch and reload <= 0;
  - otherwise counter <= counter-1.
  - If the resulting counter is 0 and irq_en=1, set pending.
- irq = ~pending.

## Timing
- Outputs cpu_bs, cpu_enable, cpu_read, ppu_bs and ciram_a10 are combinational from registers and inputs; there is no added latency.
- A register write takes effect on mapping from the m2 falling edge it is captured on.
- irq falls on the same m2 falling edge that the counted edge reaches 0.
- Reset (async, any time, including mid-write):
  - R0-R6=0, R7=1;
  - prg_mode=0, chr_inv=0, mirror=0;
  - latch=0, counter=0, reload=0;
  - irq_en=0, pending=0, so irq=1;
  - low_cnt=0 and previous A12 sample=0.
- After reset, the first A12 rise is counted only after A12_FILTER low samples.
- Simultaneous events on one edge:
  - A $C001 write plus a counted edge: the counter loads latch and reload ends at 0.
  - A $C000 write plus a reloading edge: the new latch value is loaded.
  - A $E000 write plus a counter-zero edge: pending stays 0.
  - A $E001 write plus a counter-zero edge: pending sets.
- latch=0 with irq_en=1: every counted edge asserts pending.
- Counter wrap: counting down from 0 never occurs; 0 always reloads.

## Test plan
- Reset → cpu_bs for $8000 = {8'h00,0}, $E000 = {8'hFF,0}, $C000 = {8'hFE,0}; irq=1; ciram_a10 follows ppu_addr[10].
- Write $8000=$46, $8001=$05 (R6=5, mode 1) → $8000 maps to bank $FE, $C000 to bank $05; cpu_bs at $D000 = {8'h05,1}.
- Write $8000=$80 then R0=$13 → ppu_addr $1400 gives ppu_bs=$13 (slot 5 → k=1, a10=1, {R0[7:1],1}); $0000 reads R2.
- $C000=2, $C001, $E001, then clean A12 pulses (A12_FILTER lows each) → irq falls on the 3rd counted rise; $E000 returns irq to 1.
- A12 glitch with only 1 low sample between rises (A12_FILTER=3) → not counted; counter unchanged.
- Assert reset_pin mid-sequence with pending=1 → irq=1 immediately, all registers at reset values.
